// File: rtl/pipe_ctrl_stage_if.sv
// ID/EX control-stage bundle: ID-side request and hazard inputs plus registered EX controls.
// slave is the control stage itself; master is whatever drives the ID side and observes EX.
interface pipe_ctrl_stage_if #(
    parameter int ALUOP_W = 2
);
    logic               Valid_i;
    logic [6:0]         Op_i;
    logic [6:0]         Funct7_i;
    logic               NoOp_i;
    logic               Flush_i;
    logic               Stall_i;
    logic [ALUOP_W-1:0] ALUOp_o;
    logic               ALUSrc_o;
    logic               RegWrite_o;
    logic               MemtoReg_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               Branch_o;
    logic               MulOp_o;
    logic               Illegal_o;
    logic               Valid_o;
    logic               MulBusy_o;

    modport slave (
        input  Valid_i, Op_i, Funct7_i, NoOp_i, Flush_i, Stall_i,
        output ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               Branch_o, MulOp_o, Illegal_o, Valid_o, MulBusy_o
    );

    modport master (
        output Valid_i, Op_i, Funct7_i, NoOp_i, Flush_i, Stall_i,
        input  ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               Branch_o, MulOp_o, Illegal_o, Valid_o, MulBusy_o
    );
endinterface

// File: rtl/pipe_ctrl_stage.sv
// Registered RV32I main decoder with ID/EX bubble/flush/stall handling and a
// fixed-latency multiply sequencer that holds the front end while EX is busy.
module pipe_ctrl_stage #(
    parameter int ALUOP_W     = 2,
    parameter int MUL_LATENCY = 4,
    parameter int ENABLE_MUL  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_ctrl_stage_if.slave   bus
);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MUL_WAIT = 1'b1;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // Bundle layout, MSB first: ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead,
    // MemWrite, Branch, MulOp, Illegal, Valid.
    localparam int BW = ALUOP_W + 9;

    logic [1:0]    w_aluop;
    logic          w_alusrc;
    logic          w_regwrite;
    logic          w_memtoreg;
    logic          w_memread;
    logic          w_memwrite;
    logic          w_branch;
    logic          w_mul;
    logic          w_illegal;
    logic [BW-1:0] w_dec_bundle;

    logic [BW-1:0]      r_bundle;
    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;

    always_comb begin
        w_aluop    = 2'b00;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_mul      = 1'b0;
        w_illegal  = 1'b0;
        case (bus.Op_i)
            OP_R: begin
                if (bus.Funct7_i == F7_BASE || bus.Funct7_i == F7_ALT) begin
                    w_aluop    = 2'b11;
                    w_regwrite = 1'b1;
                end else if (bus.Funct7_i == F7_MUL && ENABLE_MUL != 0) begin
                    w_aluop    = 2'b11;
                    w_regwrite = 1'b1;
                    w_mul      = 1'b1;
                end else begin
                    w_illegal  = 1'b1;
                end
            end
            OP_IALU: begin
                w_aluop    = 2'b10;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_LW: begin
                w_aluop    = 2'b01;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_memread  = 1'b1;
            end
            OP_SW: begin
                w_aluop    = 2'b01;
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_branch   = 1'b1;
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    assign w_dec_bundle = {ALUOP_W'(w_aluop), w_alusrc, w_regwrite, w_memtoreg,
                           w_memread, w_memwrite, w_branch, w_mul, w_illegal, 1'b1};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bundle <= '0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
        end else if (bus.Flush_i) begin
            r_bundle <= '0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
        end else if (r_state == S_MUL_WAIT) begin
            // Multiply occupies EX: hold the slot, count down even under stall.
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_state <= S_IDLE;
            end
        end else if (bus.Stall_i) begin
            r_bundle <= r_bundle;
        end else if (bus.NoOp_i || !bus.Valid_i) begin
            r_bundle <= '0;
        end else begin
            r_bundle <= w_dec_bundle;
            if (w_mul && MUL_LATENCY > 1) begin
                r_state <= S_MUL_WAIT;
                r_cnt   <= CNT_INIT;
            end
        end
    end

    assign bus.ALUOp_o    = r_bundle[BW-1 -: ALUOP_W];
    assign bus.ALUSrc_o   = r_bundle[8];
    assign bus.RegWrite_o = r_bundle[7];
    assign bus.MemtoReg_o = r_bundle[6];
    assign bus.MemRead_o  = r_bundle[5];
    assign bus.MemWrite_o = r_bundle[4];
    assign bus.Branch_o   = r_bundle[3];
    assign bus.MulOp_o    = r_bundle[2];
    assign bus.Illegal_o  = r_bundle[1];
    assign bus.Valid_o    = r_bundle[0];
    assign bus.MulBusy_o  = (r_state == S_MUL_WAIT);
endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Registered, hazard-aware control stage for the 5-stage RV32I pipeline, replacing the purely combinational main decoder. Decodes the ID-stage opcode, extended with funct7 for the M-extension multiply, into the ID/EX control bundle and holds it in a pipeline register. Supports bubble insertion, flush and downstream stall. Sequences a fixed-latency multi-cycle multiply and raises a front-end stall while it is in flight.

## Interface

Parameters:
- `ALUOP_W`, default 2: ALUOp width. Values below 2 are not supported.
- `MUL_LATENCY`, default 4: cycles a MUL occupies the EX stage. Legal range is 1 to 16.
- `ENABLE_MUL`, default 1: when 0, a funct7=0000001 R-type decodes as illegal.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Asynchronous, active-high.
- `Valid_i` in 1: the ID stage holds a real instruction.
- `Op_i` in 7: opcode, instr[6:0].
- `Funct7_i` in 7: instr[31:25].
- `NoOp_i` in 1: hazard unit requests a bubble.
- `Flush_i` in 1: branch-taken flush.
- `Stall_i` in 1: downstream hold.
- `ALUOp_o` out ALUOP_W: registered ALUOp.
- `ALUSrc_o`, `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o`, `Branch_o` out 1 each: registered controls.
- `MulOp_o` out 1: EX holds a multiply.
- `Illegal_o` out 1: EX slot came from an unrecognised opcode.
- `Valid_o` out 1: EX slot holds a real instruction.
- `MulBusy_o` out 1: front end must hold IF/ID.

## Operation

- **Decode table** (combinational, internal). Fields are listed as ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch.
  - 0110011 (R): 11,0,1,0,0,0,0. Sets mul when Funct7_i=0000001 and ENABLE_MUL=1.
  - 0010011 (I-ALU): 10,1,1,0,0,0,0.
  - 0000011 (lw): 01,1,1,1,1,0,0.
  - 0100011 (sw): 01,1,0,0,0,1,0.
  - 1100011 (beq): 00,0,0,0,0,0,1.
  - Any other opcode: all zero, with illegal=1.
  - R-type with an unsupported funct7 (anything other than 0000000 or 0100000, or 0000001 when ENABLE_MUL=0): all zero, with illegal=1.
- **Bubble.** All control fields, MulOp, Valid and Illegal are 0.
- **Register update**, evaluated each rising edge in priority order:
  1. `Flush_i`: load bubble, clear the multiply counter, return to IDLE.
  2. State MUL_WAIT: hold the register.
  3. `Stall_i`: hold the register.
  4. `NoOp_i` or `!Valid_i`: load bubble.
  5. Otherwise: load the decoded bundle with Valid=1.
- **Illegal instructions.** Load all-zero controls with Valid=1 and Illegal=1. Illegal lasts exactly as long as that slot is held.
- **Multiply FSM**, states IDLE and MUL_WAIT, with counter `cnt`:
  - IDLE to MUL_WAIT: a mul bundle is loaded (rule 5) and MUL_LATENCY>1. Load cnt=MUL_LATENCY-1.
  - In MUL_WAIT, cnt decrements every cycle regardless of `Stall_i`.
  - MUL_WAIT to IDLE: when cnt decrements from 1 to 0, or on `Flush_i`.
  - `MulBusy_o` = (state==MUL_WAIT), driven directly from the state register.
  - MUL_LATENCY=1: no MUL_WAIT. The multiply behaves like any R-type and MulBusy_o never asserts.
- **Upstream contract.** Upstream keeps `Op_i`, `Funct7_i` and `Valid_i` stable while `MulBusy_o` or `Stall_i` is high. The block ignores those inputs in those cycles.
- **Reset.** Every output is 0, state is IDLE and cnt is 0. Reset mid-multiply aborts the multiply immediately.

## Timing

- Input to output latency is 1 cycle. All outputs are registered; there are no combinational paths from input to output.
- A multiply is captured at edge E. It is visible on outputs for cycles E through E+MUL_LATENCY-1. MulBusy_o is high for cycles E through E+MUL_LATENCY-2. The next instruction loads at edge E+MUL_LATENCY.
- If `Stall_i` is still high when MUL_WAIT exits, the register keeps holding the multiply until `Stall_i` drops.
- `Flush_i` together with `Stall_i`: flush wins.
- `Flush_i` together with a multiply decode: flush wins and the multiply is never captured.

## Test plan

- **Reset, then basic R-type.** Assert rst_i mid-cycle. All outputs go to 0 asynchronously. Then drive Valid=1, Op=0110011, Funct7=0. Next cycle: ALUOp=11, RegWrite=1, Valid_o=1, everything else 0.
- **Load then store, back to back.** lw gives ALUOp=01, ALUSrc=1, RegWrite=1, MemtoReg=1, MemRead=1. The following cycle, sw gives ALUOp=01, ALUSrc=1, MemWrite=1, RegWrite=0.
- **Multiply, MUL_LATENCY=4.** Drive Op=0110011, Funct7=0000001. MulOp_o is high for 4 cycles and MulBusy_o for the first 3. An add presented throughout appears on the 5th cycle.
- **Flush during multiply.** Assert Flush_i on the 2nd busy cycle. Next cycle: all outputs 0, MulBusy_o=0. The next instruction loads on the following edge.
- **Stall and NoOp.** Stall_i high for 3 cycles holds a beq bundle (Branch_o=1) unchanged. NoOp_i together with a valid lw produces all zeros, Valid_o=0.
- **Illegal opcode.** Op=1111111 gives Illegal_o=1, Valid_o=1, all controls 0. With ENABLE_MUL=0, Funct7=0000001 also gives Illegal_o=1 and MulBusy_o never asserts.
